remote_comm: RTL and testbench

Host-side command sender for the serial command link. Accepts a 16-bit command in one cycle, serialises it as two UART bytes (high byte first, then low byte), then waits up to a programmable timeout for the single 8-bit response byte. The receiving end is `UART_wrapper`, which reassembles the two bytes into its `cmd` and returns `resp`. The block is used in the remote/test-harness side of the system and in the system-level bench.

---
 rtl/remote_comm_pkg.sv | 14 +
 rtl/UART.sv | 101 ++++++++++
 rtl/remote_comm.sv | 152 +++++++++++++++
 tb/tb_remote_comm.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/remote_comm_pkg.sv
// Shared types and widths for the host-side serial command sender.
package remote_comm_pkg;
    localparam int CMD_W  = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO,
        WAIT_RESP
    } rc_state_t;
endpackage

// File: rtl/UART.sv
// 8N1 UART: trmt starts a frame and clears tx_done; rx_rdy holds until clr_rx_rdy.
// BAUD_DIV clocks per bit; the receiver samples at bit centres after a 2-flop synchroniser.
module UART #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    input  logic       RX,
    input  logic       clr_rx_rdy,
    output logic       rx_rdy,
    output logic [7:0] rx_data
);
    logic [9:0]  r_tx_shft;
    logic [15:0] r_tx_baud;
    logic [3:0]  r_tx_bits;
    logic        r_tx_busy;
    logic        r_tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shft <= '1;
            r_tx_baud <= '0;
            r_tx_bits <= '0;
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b0;
        end else if (trmt) begin
            r_tx_shft <= {1'b1, tx_data, 1'b0};
            r_tx_baud <= '0;
            r_tx_bits <= '0;
            r_tx_busy <= 1'b1;
            r_tx_done <= 1'b0;
        end else if (r_tx_busy) begin
            if (r_tx_baud == 16'(BAUD_DIV - 1)) begin
                r_tx_baud <= '0;
                r_tx_shft <= {1'b1, r_tx_shft[9:1]};
                if (r_tx_bits == 4'd9) begin
                    r_tx_busy <= 1'b0;
                    r_tx_done <= 1'b1;
                end else begin
                    r_tx_bits <= r_tx_bits + 4'd1;
                end
            end else begin
                r_tx_baud <= r_tx_baud + 16'd1;
            end
        end
    end

    assign TX      = r_tx_shft[0];
    assign tx_done = r_tx_done;

    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_busy;
    logic        r_rx_rdy;
    logic [15:0] r_rx_cnt;
    logic [3:0]  r_rx_bits;
    logic [7:0]  r_rx_shft;

    // The stop bit is also sampled so the line is high again before we re-arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_busy <= 1'b0;
            r_rx_rdy  <= 1'b0;
            r_rx_cnt  <= '0;
            r_rx_bits <= '0;
            r_rx_shft <= '0;
        end else begin
            r_rx_s1 <= RX;
            r_rx_s2 <= r_rx_s1;
            if (clr_rx_rdy)
                r_rx_rdy <= 1'b0;
            if (!r_rx_busy) begin
                if (!r_rx_s2) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= 16'(BAUD_DIV + BAUD_DIV / 2 - 1);
                    r_rx_bits <= '0;
                end
            end else if (r_rx_cnt == 16'd0) begin
                r_rx_cnt <= 16'(BAUD_DIV - 1);
                if (r_rx_bits == 4'd8) begin
                    r_rx_busy <= 1'b0;
                    r_rx_rdy  <= 1'b1;
                end else begin
                    r_rx_shft <= {r_rx_s2, r_rx_shft[7:1]};
                    r_rx_bits <= r_rx_bits + 4'd1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt - 16'd1;
            end
        end
    end

    assign rx_rdy  = r_rx_rdy;
    assign rx_data = r_rx_shft;
endmodule

// File: rtl/remote_comm.sv
// Sends a 16-bit command as two UART bytes (high first) and waits up to
// RESP_TIMEOUT cycles for a one-byte response; snd_cmd is ignored while busy.
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int RESP_TIMEOUT = 1_000_000,
    parameter int BAUD_DIV     = 2604
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              snd_cmd,
    input  logic [CMD_W-1:0]  cmd,
    input  logic              clr_resp_rdy,
    input  logic              RX,
    output logic              TX,
    output logic              busy,
    output logic              cmd_snt,
    output logic              resp_rdy,
    output logic [BYTE_W-1:0] resp,
    output logic              resp_tmo
);
    localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);

    rc_state_t         r_state;
    rc_state_t         w_nxt_state;
    logic [CMD_W-1:0]  r_buf;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cmd_snt;
    logic              r_resp_rdy;
    logic [BYTE_W-1:0] r_resp;
    logic              r_resp_tmo;

    logic              w_trmt;
    logic [BYTE_W-1:0] w_tx_data;
    logic              w_tx_done;
    logic              w_rx_rdy;
    logic [BYTE_W-1:0] w_rx_data;
    logic              w_clr_rx_rdy;
    logic              w_accept;
    logic              w_set_snt;
    logic              w_got_resp;
    logic              w_set_tmo;

    UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (~rst),
        .trmt       (w_trmt),
        .tx_data    (w_tx_data),
        .TX         (TX),
        .tx_done    (w_tx_done),
        .RX         (RX),
        .clr_rx_rdy (w_clr_rx_rdy),
        .rx_rdy     (w_rx_rdy),
        .rx_data    (w_rx_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state = r_state;
        w_trmt      = 1'b0;
        w_tx_data   = r_buf[CMD_W-1 -: BYTE_W];
        w_accept    = 1'b0;
        w_set_snt   = 1'b0;
        w_got_resp  = 1'b0;
        w_set_tmo   = 1'b0;
        case (r_state)
            IDLE: begin
                if (snd_cmd) begin
                    w_accept    = 1'b1;
                    w_nxt_state = SEND_HI;
                end
            end
            SEND_HI: begin
                w_trmt      = 1'b1;
                w_nxt_state = WAIT_HI;
            end
            WAIT_HI: begin
                if (w_tx_done)
                    w_nxt_state = SEND_LO;
            end
            SEND_LO: begin
                w_trmt      = 1'b1;
                w_tx_data   = r_buf[BYTE_W-1:0];
                w_nxt_state = WAIT_LO;
            end
            WAIT_LO: begin
                if (w_tx_done) begin
                    w_set_snt   = 1'b1;
                    w_nxt_state = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response arriving on the timeout cycle takes priority.
                if (w_rx_rdy) begin
                    w_got_resp  = 1'b1;
                    w_nxt_state = IDLE;
                end else if (r_cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
                    w_set_tmo   = 1'b1;
                    w_nxt_state = IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // Every received byte is acknowledged; outside WAIT_RESP it is simply dropped.
    assign w_clr_rx_rdy = w_rx_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf      <= '0;
            r_cnt      <= '0;
            r_cmd_snt  <= 1'b0;
            r_resp_rdy <= 1'b0;
            r_resp     <= '0;
            r_resp_tmo <= 1'b0;
        end else begin
            if (w_accept)
                r_buf <= cmd;
            if (w_set_snt)
                r_cnt <= '0;
            else if (r_state == WAIT_RESP)
                r_cnt <= r_cnt + 1'b1;
            if (w_accept)
                r_cmd_snt <= 1'b0;
            else if (w_set_snt)
                r_cmd_snt <= 1'b1;
            if (w_got_resp)
                r_resp <= w_rx_data;
            if (w_got_resp)
                r_resp_rdy <= 1'b1;
            else if (w_accept || clr_resp_rdy)
                r_resp_rdy <= 1'b0;
            if (w_accept)
                r_resp_tmo <= 1'b0;
            else if (w_set_tmo)
                r_resp_tmo <= 1'b1;
        end
    end

    assign busy     = (r_state != IDLE);
    assign cmd_snt  = r_cmd_snt;
    assign resp_rdy = r_resp_rdy;
    assign resp     = r_resp;
    assign resp_tmo = r_resp_tmo;
endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: a behavioural serial far end decodes TX and drives RX.
module tb_remote_comm;
    import remote_comm_pkg::*;

    localparam int RT = 500;
    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        snd_cmd;
    logic [15:0] cmd;
    logic        clr_resp_rdy;
    logic        RX;
    logic        TX;
    logic        busy;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        resp_tmo;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    remote_comm #(.RESP_TIMEOUT(RT), .BAUD_DIV(BD)) dut (
        .clk          (clk),
        .rst          (rst),
        .snd_cmd      (snd_cmd),
        .cmd          (cmd),
        .clr_resp_rdy (clr_resp_rdy),
        .RX           (RX),
        .TX           (TX),
        .busy         (busy),
        .cmd_snt      (cmd_snt),
        .resp_rdy     (resp_rdy),
        .resp         (resp),
        .resp_tmo     (resp_tmo)
    );

    typedef struct {
        logic [15:0] cmd;
        bit          respond;
        logic [7:0]  rbyte;
        logic [15:0] exp_cmd;
        logic        exp_rdy;
        logic [7:0]  exp_resp;
        logic        exp_tmo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic far_rx_byte(output logic [7:0] b);
        int n = 0;
        b = '0;
        while (TX !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_start_seen", 32'(n < 4000), 1);
        repeat (BD / 2) @(negedge clk);
        chk("tx_start_bit", TX, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (BD) @(negedge clk);
            b[i] = TX;
        end
        repeat (BD) @(negedge clk);
        chk("tx_stop_bit", TX, 1);
    endtask

    task automatic far_tx_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (BD) @(negedge clk);
        end
        RX = 1'b1;
    endtask

    task automatic do_send(input logic [15:0] c, output logic [15:0] got);
        logic [7:0] hi;
        logic [7:0] lo;
        @(negedge clk);
        cmd     = c;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        chk("busy_cycle1", busy, 1);
        chk("snt_cleared", cmd_snt, 0);
        chk("rdy_cleared", resp_rdy, 0);
        chk("tmo_cleared", resp_tmo, 0);
        chk("tx_idle_cycle1", TX, 1);
        @(negedge clk);
        chk("tx_start_cycle2", TX, 0);
        far_rx_byte(hi);
        far_rx_byte(lo);
        got = {hi, lo};
    endtask

    task automatic wait_snt();
        int n = 0;
        while (cmd_snt !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_snt_rise", cmd_snt, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic collide_mon();
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (dut.w_rx_rdy === 1'b1) begin
                seen = 1'b1;
                clr_resp_rdy = 1'b1;
                @(negedge clk);
                clr_resp_rdy = 1'b0;
                chk("rdy_set_beats_clr", resp_rdy, 1);
            end
        end
        chk("collision_seen", 32'(seen), 1);
    endtask

    vec_t        vt[4];
    logic [15:0] got;
    logic [7:0]  hi_b;
    int          n;
    int          bad;

    initial begin
        vt[0] = '{16'hA55A, 1'b1, 8'hA5, 16'hA55A, 1'b1, 8'hA5, 1'b0};
        vt[1] = '{16'h0000, 1'b1, 8'hFF, 16'h0000, 1'b1, 8'hFF, 1'b0};
        vt[2] = '{16'hFFFF, 1'b0, 8'h00, 16'hFFFF, 1'b0, 8'hFF, 1'b1};
        vt[3] = '{16'h8001, 1'b1, 8'h01, 16'h8001, 1'b1, 8'h01, 1'b0};

        rst = 1'b1; snd_cmd = 1'b0; cmd = '0; clr_resp_rdy = 1'b0; RX = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_snt", cmd_snt, 0);
        chk("rst_resp_rdy", resp_rdy, 0);
        chk("rst_resp_tmo", resp_tmo, 0);
        chk("rst_resp", resp, 8'h00);
        chk("rst_tx", TX, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            do_send(vt[i].cmd, got);
            chk("far_cmd", got, vt[i].exp_cmd);
            wait_snt();
            if (vt[i].respond) begin
                far_tx_byte(vt[i].rbyte);
                wait_idle();
            end else begin
                n = 0;
                while (resp_tmo !== 1'b1 && n < RT + 100) begin
                    @(negedge clk);
                    n++;
                end
                chk("tmo_cycles", n, RT);
            end
            chk("vec_resp_rdy", resp_rdy, vt[i].exp_rdy);
            chk("vec_resp", resp, vt[i].exp_resp);
            chk("vec_resp_tmo", resp_tmo, vt[i].exp_tmo);
            chk("vec_busy", busy, 0);
        end

        // Unsolicited byte during WAIT_HI, then a response colliding with clr_resp_rdy.
        fork
            do_send(16'h5AC3, got);
            begin
                repeat (2) @(negedge clk);
                far_tx_byte(8'h77);
            end
        join
        chk("unsol_far_cmd", got, 16'h5AC3);
        chk("unsol_rdy", resp_rdy, 0);
        chk("unsol_resp", resp, 8'h01);
        wait_snt();
        fork
            far_tx_byte(8'h3C);
            collide_mon();
        join
        chk("coll_resp_rdy", resp_rdy, 1);
        chk("coll_resp", resp, 8'h3C);
        chk("coll_busy", busy, 0);
        @(negedge clk);
        clr_resp_rdy = 1'b1;
        @(negedge clk);
        clr_resp_rdy = 1'b0;
        chk("clr_resp_rdy", resp_rdy, 0);

        // snd_cmd while busy is ignored.
        fork
            do_send(16'hBEEF, got);
            begin
                repeat (40) @(negedge clk);
                cmd     = 16'h1234;
                snd_cmd = 1'b1;
                @(negedge clk);
                snd_cmd = 1'b0;
            end
        join
        chk("busy_far_cmd", got, 16'hBEEF);
        wait_snt();
        far_tx_byte(8'h11);
        wait_idle();
        chk("busy_resp", resp, 8'h11);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (TX !== 1'b1 || busy !== 1'b0)
                bad++;
        end
        chk("no_second_cmd", bad, 0);

        // Reset in the middle of the low byte.
        @(negedge clk);
        cmd     = 16'hC3A5;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        far_rx_byte(hi_b);
        chk("mid_hi_byte", hi_b, 8'hC3);
        repeat (BD * 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_snt", cmd_snt, 0);
        chk("mid_rst_rdy", resp_rdy, 0);
        chk("mid_rst_tmo", resp_tmo, 0);
        chk("mid_rst_resp", resp, 8'h00);
        chk("mid_rst_tx", TX, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (BD * 12) @(negedge clk);
        do_send(16'h00FF, got);
        chk("post_rst_far_cmd", got, 16'h00FF);
        wait_snt();
        far_tx_byte(8'hC6);
        wait_idle();
        chk("post_rst_rdy", resp_rdy, 1);
        chk("post_rst_resp", resp, 8'hC6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
